cell_vector_tester: RTL and testbench
=====================================

Name: cell_vector_tester

Overview:
- Wishbone-controlled stimulus generator and response compactor for the standard-cell test array.
- Drives a vector bus into the cell inputs. After a programmable settle time it captures the cell outputs and folds each capture into a 32-bit MISR signature.
- Sits in the user project area, mapped on the Wishbone slave port. It is the driving and observing end of the cell-array input/output interface, which is otherwise exercised from off-chip pins.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base; adr[31:8] must match BASE_ADDR[31:8].
- STIM_W, 24, stimulus vector width (2..32).
- RESP_W, 16, response width (1..32).
- SETTLE_CYCLES, 4, clocks between applying a vector and capturing it (1..255).
- LFSR_TAPS, 24'hE10000, Galois feedback mask for LFSR mode (STIM_W bits).
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- stim_o  out  STIM_W  vector driven to the cell inputs.
- stim_valid_o  out  1  high while stim_o holds a test vector.
- resp_i  in  RESP_W  cell outputs.
- busy_o  out  1  run in progress.
- done_irq_o  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (wb_rst_i low at a clock edge): all outputs 0, FSM IDLE, all registers 0, sticky done 0.
- Reset mid-run aborts the run immediately and gives the same values.

Wishbone:
- Access is stb & cyc & address match & !ack.
- ack is registered: high exactly one cycle after access detection, then low for at least one cycle.
- Read data is valid in the ack cycle. Unmapped offsets read 0 and ignore writes.
- Non-matching addresses are never acked.
- sel_i applies per byte to NUM_VEC and SEED.

Register map (offset, fields):
- 0x00 CTRL
  - bit0 START: write-1 pulse, reads 0.
  - bit1 MODE: 0 = counter, 1 = LFSR.
  - bit2 ABORT: write-1 pulse, reads 0.
- 0x04 STATUS (read-only): bit0 busy, bit1 done (sticky).
- 0x08 NUM_VEC[15:0].
- 0x0C SEED[STIM_W-1:0].
- 0x10 SIGNATURE[31:0] (read-only).
- 0x14 VEC_DONE[15:0] (read-only).
- 0x18 LAST_RESP[RESP_W-1:0] (read-only).

Register write rules:
- Writes to MODE, NUM_VEC and SEED while busy are ignored.
- START while busy is ignored.
- ABORT while idle has no effect.

FSM states: IDLE, APPLY, SETTLE, CAPTURE.

- IDLE
  - On START (effective in the ack cycle): clear SIGNATURE, VEC_DONE and done; load vec from SEED.
  - In LFSR mode a SEED of 0 loads 1.
  - If NUM_VEC = 0: set done, pulse done_irq_o, stay IDLE.
  - Otherwise go to APPLY.
- APPLY (1 cycle): stim_o <= vec, stim_valid_o <= 1; go to SETTLE with cnt = SETTLE_CYCLES-1.
- SETTLE: decrement cnt; at 0 go to CAPTURE.
- CAPTURE (1 cycle)
  - LAST_RESP <= resp_i.
  - SIGNATURE <= {sig[30:0],1'b0} ^ (sig[31] ? MISR_POLY : 0) ^ zero-extended resp_i.
  - VEC_DONE increments.
  - Next vec: counter mode is vec+1 modulo 2^STIM_W (wraps to 0); LFSR mode is Galois shift right with LFSR_TAPS XORed when the LSB is 1.
  - If VEC_DONE+1 = NUM_VEC: go to IDLE, set done, pulse done_irq_o, drop stim_valid_o (stim_o holds the last vector).
  - Else go to APPLY.
- Run timing:
  - Per-vector period is SETTLE_CYCLES+2 clocks.
  - A run lasts NUM_VEC*(SETTLE_CYCLES+2) clocks after START.
- ABORT from any busy state:
  - Next cycle: IDLE, stim_valid_o 0, done stays 0, no irq.
  - SIGNATURE and VEC_DONE keep their partial values.
- busy_o = (state != IDLE).
- The start cycle itself performs no capture.

Test Plan:
- Reset, then read all offsets -> zeros; an access outside BASE_ADDR -> no ack. Write NUM_VEC with sel=4'b0001, data 0x1234 -> NUM_VEC reads 0x0034.
- Counter mode, SEED=0, NUM_VEC=4, resp_i=0 -> stim_o steps 0,1,2,3 every 6 clocks; SIGNATURE=0, VEC_DONE=4, done=1, one done_irq_o pulse.
- Counter mode, NUM_VEC=2, resp_i=16'h0001 -> SIGNATURE=0x00000003, LAST_RESP=0x0001. Repeat the start -> SIGNATURE is cleared and again 0x00000003.
- Counter wrap and LFSR seed handling:
  - Counter mode, SEED=24'hFFFFFF, NUM_VEC=2 -> stim_o FFFFFF then 000000.
  - LFSR mode, SEED=0 -> first stim_o = 000001.
- NUM_VEC=0 START -> done=1 next cycle, stim_valid_o never asserted.
- Busy-state controls and reset:
  - NUM_VEC=100, ABORT after 3 vectors -> VEC_DONE=3, done=0, busy 0.
  - SEED writes during a run are ignored.
  - wb_rst_i low mid-run -> all outputs 0.

Source files
------------

// File: rtl/cell_vector_tester.sv
// cell_vector_tester: Wishbone-controlled stimulus generator and MISR
// response compactor for the standard-cell test array. Each vector is
// applied, held for SETTLE_CYCLES clocks, then the cell outputs are folded
// into a 32-bit signature.
module cell_vector_tester #(
  parameter logic [31:0]       BASE_ADDR     = 32'h3000_0000,
  parameter int                STIM_W        = 24,
  parameter int                RESP_W        = 16,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [STIM_W-1:0] LFSR_TAPS     = 24'hE10000,
  parameter logic [31:0]       MISR_POLY     = 32'h04C11DB7
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [STIM_W-1:0] stim_o,
  output logic              stim_valid_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o,
  output logic              done_irq_o
);

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [STIM_W-1:0] vec_q, vec_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic              stimValid_q, stimValid_d;
  logic [31:0]       sig_q, sig_d;
  logic [15:0]       vecDone_q, vecDone_d;
  logic [RESP_W-1:0] lastResp_q, lastResp_d;
  logic [15:0]       numVec_q, numVec_d;
  logic [STIM_W-1:0] seed_q, seed_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              access;
  logic              wrAccess;
  logic [7:0]        offset;
  logic              busy;
  logic              startReq;
  logic              abortReq;
  logic [31:0]       rdData;
  logic              unusedBits;

  // Not every write-data or byte-enable bit lands in a register for every
  // width configuration; fold them so they count as consumed.
  assign unusedBits = ^{wbs_dat_i, wbs_sel_i};

  assign access   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wrAccess = access & wbs_we_i;
  assign offset   = wbs_adr_i[7:0];
  assign busy     = (state_q != IDLE);
  assign startReq = wrAccess && (offset == 8'h00) && wbs_dat_i[0];
  assign abortReq = wrAccess && (offset == 8'h00) && wbs_dat_i[2];

  // Read multiplexer: selects the register addressed by the current access.
  always_comb begin
    rdData = '0;
    case (offset)
      8'h00:   rdData = {30'd0, mode_q, 1'b0};
      8'h04:   rdData = {30'd0, done_q, busy};
      8'h08:   rdData = {16'd0, numVec_q};
      8'h0C:   rdData = 32'(seed_q);
      8'h10:   rdData = sig_q;
      8'h14:   rdData = {16'd0, vecDone_q};
      8'h18:   rdData = 32'(lastResp_q);
      default: rdData = '0;
    endcase
  end

  // Next-state logic: bus handshake, register writes, and the run FSM that
  // applies, settles and captures each vector.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    stim_d      = stim_q;
    stimValid_d = stimValid_q;
    sig_d       = sig_q;
    vecDone_d   = vecDone_q;
    lastResp_d  = lastResp_q;
    numVec_d    = numVec_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    done_d      = done_q;
    irq_d       = 1'b0;
    ack_d       = access;
    dat_d       = (access && !wbs_we_i) ? rdData : 32'd0;

    if (wrAccess && !busy) begin
      case (offset)
        8'h00: mode_d = wbs_dat_i[1];
        8'h08: begin
          for (int i = 0; i < 16; i++) begin
            if (wbs_sel_i[i/8]) numVec_d[i] = wbs_dat_i[i];
          end
        end
        8'h0C: begin
          for (int i = 0; i < STIM_W; i++) begin
            if (wbs_sel_i[i/8]) seed_d[i] = wbs_dat_i[i];
          end
        end
        default: ;
      endcase
    end

    if (abortReq && busy) begin
      state_d     = IDLE;
      stimValid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startReq) begin
            sig_d     = '0;
            vecDone_d = '0;
            done_d    = 1'b0;
            vec_d     = (mode_d && (seed_q == '0)) ? STIM_W'(1) : seed_q;
            if (numVec_q == 16'd0) begin
              done_d = 1'b1;
              irq_d  = 1'b1;
            end else begin
              state_d = APPLY;
            end
          end
        end
        APPLY: begin
          stim_d      = vec_q;
          stimValid_d = 1'b1;
          cnt_d       = 8'(SETTLE_CYCLES - 1);
          state_d     = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == 8'd0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        CAPTURE: begin
          lastResp_d = resp_i;
          sig_d      = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'd0) ^ 32'(resp_i);
          vecDone_d  = vecDone_q + 16'd1;
          if (mode_q) begin
            vec_d = (vec_q >> 1) ^ (vec_q[0] ? LFSR_TAPS : '0);
          end else begin
            vec_d = vec_q + STIM_W'(1);
          end
          if ((vecDone_q + 16'd1) == numVec_q) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            irq_d       = 1'b1;
            stimValid_d = 1'b0;
          end else begin
            state_d = APPLY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      stim_q      <= '0;
      stimValid_q <= 1'b0;
      sig_q       <= '0;
      vecDone_q   <= '0;
      lastResp_q  <= '0;
      numVec_q    <= '0;
      seed_q      <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      stim_q      <= stim_d;
      stimValid_q <= stimValid_d;
      sig_q       <= sig_d;
      vecDone_q   <= vecDone_d;
      lastResp_q  <= lastResp_d;
      numVec_q    <= numVec_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign stim_o       = stim_q;
  assign stim_valid_o = stimValid_q;
  assign busy_o       = busy;
  assign done_irq_o   = irq_q;

endmodule

// File: tb/tb_cell_vector_tester.sv
// tb_cell_vector_tester: drives the tester over Wishbone, and compares the
// applied vectors, bus status and final signature against a reference
// model built from the vector-sequence and MISR rules.
module tb_cell_vector_tester;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          S    = 4;
  localparam int          P    = S + 2;

  logic        clk;
  logic        rst_n;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [23:0] stim_o;
  logic        stim_valid_o;
  logic [15:0] resp_i;
  logic        busy_o;
  logic        done_irq_o;

  int checks = 0;
  int errors = 0;
  int irqCount = 0;

  cell_vector_tester dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .stim_o      (stim_o),
    .stim_valid_o(stim_valid_o),
    .resp_i      (resp_i),
    .busy_o      (busy_o),
    .done_irq_o  (done_irq_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts completion interrupt pulses.
  always @(negedge clk) begin
    if (done_irq_o) irqCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] lfsrStep(input logic [23:0] v);
    return (v >> 1) ^ (v[0] ? 24'hE10000 : 24'd0);
  endfunction

  function automatic logic [31:0] misrStep(input logic [31:0] s, input logic [15:0] r);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'd0) ^ {16'd0, r};
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data,
                               input logic [3:0] sel, output logic [31:0] rdata, output bit acked);
    if (wbs_ack_o) @(negedge clk);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = data;
    wbs_sel_i = sel;
    acked = 1'b0;
    rdata = 32'd0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] rd;
    bit acked;
    applyStimulus(1'b1, BASE | 32'(off), data, sel, rd, acked);
    checkOutput("wrAck", 32'(acked), 32'd1);
  endtask

  task automatic wbRead(input logic [7:0] off, output logic [31:0] data);
    bit acked;
    applyStimulus(1'b0, BASE | 32'(off), 32'd0, 4'hF, data, acked);
    checkOutput("rdAck", 32'(acked), 32'd1);
  endtask

  // One complete run: configure, start, follow the vector timing cycle by
  // cycle, then compare the final registers with the model.
  task automatic runVectors(input bit mode, input logic [23:0] seed, input int n,
                            input bit randResp, input logic [15:0] fixedResp);
    logic [23:0] vecs[$];
    logic [23:0] v;
    logic [31:0] sig;
    logic [15:0] lastR;
    logic [15:0] r;
    logic [31:0] rd;
    int irqBefore;
    v = (mode && seed == 24'd0) ? 24'd1 : seed;
    for (int k = 0; k < n; k++) begin
      vecs.push_back(v);
      v = mode ? lfsrStep(v) : v + 24'd1;
    end
    sig = 32'd0;
    lastR = 16'd0;
    wbWrite(8'h08, 32'(n), 4'hF);
    wbWrite(8'h0C, 32'(seed), 4'hF);
    irqBefore = irqCount;
    wbWrite(8'h00, {30'd0, mode, 1'b1}, 4'hF);
    for (int m = 1; m <= n * P; m++) begin
      r = randResp ? 16'($urandom) : fixedResp;
      resp_i = r;
      if (m % P == 0) begin
        sig = misrStep(sig, r);
        lastR = r;
      end
      @(negedge clk);
      if ((m - 1) % P == 0) begin
        checkOutput("stim", 32'(stim_o), 32'(vecs[(m - 1) / P]));
        checkOutput("stimValid", 32'(stim_valid_o), 32'd1);
      end
      if (m == n * P - 1) checkOutput("busyLate", 32'(busy_o), 32'd1);
      if (m == n * P) begin
        checkOutput("busyEnd", 32'(busy_o), 32'd0);
        checkOutput("irqEnd", 32'(done_irq_o), 32'd1);
        checkOutput("validEnd", 32'(stim_valid_o), 32'd0);
        checkOutput("stimHold", 32'(stim_o), 32'(vecs[n - 1]));
      end
    end
    wbRead(8'h10, rd);
    checkOutput("signature", rd, sig);
    wbRead(8'h14, rd);
    checkOutput("vecDone", rd, 32'(n));
    wbRead(8'h18, rd);
    checkOutput("lastResp", rd, {16'd0, lastR});
    wbRead(8'h04, rd);
    checkOutput("statusDone", rd, 32'd2);
    checkOutput("irqOnce", 32'(irqCount - irqBefore), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    logic [31:0] rd;
    bit acked;
    bit seen;
    int irqBefore;
    rst_n = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = 32'd0;
    wbs_adr_i = 32'd0;
    resp_i    = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstStim", 32'(stim_o), 32'd0);
    checkOutput("rstValid", 32'(stim_valid_o), 32'd0);
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstIrq", 32'(done_irq_o), 32'd0);
    checkOutput("rstAck", 32'(wbs_ack_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All registers read zero after reset.
    for (int off = 0; off <= 24; off += 4) begin
      wbRead(8'(off), rd);
      checkOutput("rstRead", rd, 32'd0);
    end

    // Out-of-window address is never acknowledged.
    applyStimulus(1'b0, 32'h3000_0100, 32'd0, 4'hF, rd, acked);
    checkOutput("noAckOutside", 32'(acked), 32'd0);

    // Byte enables on NUM_VEC, and an unmapped offset.
    wbWrite(8'h08, 32'h0000_1234, 4'b0001);
    wbRead(8'h08, rd);
    checkOutput("selNumVec", rd, 32'h0000_0034);
    wbWrite(8'h1C, 32'hFFFF_FFFF, 4'hF);
    wbRead(8'h1C, rd);
    checkOutput("unmapped", rd, 32'd0);

    // Directed runs.
    runVectors(1'b0, 24'h000000, 4, 1'b0, 16'h0000);
    runVectors(1'b0, 24'h000000, 2, 1'b0, 16'h0001);
    wbRead(8'h10, rd);
    checkOutput("sigConst1", rd, 32'h0000_0003);
    runVectors(1'b0, 24'h000000, 2, 1'b0, 16'h0001);
    wbRead(8'h10, rd);
    checkOutput("sigConst2", rd, 32'h0000_0003);
    runVectors(1'b0, 24'hFFFFFF, 2, 1'b1, 16'h0000);
    runVectors(1'b1, 24'h000000, 3, 1'b1, 16'h0000);

    // NUM_VEC = 0 completes immediately.
    wbWrite(8'h08, 32'd0, 4'hF);
    irqBefore = irqCount;
    wbWrite(8'h00, 32'd1, 4'hF);
    checkOutput("zeroIrq", 32'(done_irq_o), 32'd1);
    checkOutput("zeroBusy", 32'(busy_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= stim_valid_o;
    end
    checkOutput("zeroNoValid", 32'(seen), 32'd0);
    wbRead(8'h04, rd);
    checkOutput("zeroStatus", rd, 32'd2);
    checkOutput("zeroIrqOnce", 32'(irqCount - irqBefore), 32'd1);

    // Abort after three vectors; SEED write during the run is dropped.
    resp_i = 16'h0003;
    wbWrite(8'h08, 32'd100, 4'hF);
    wbWrite(8'h0C, 32'h0000_0010, 4'hF);
    irqBefore = irqCount;
    wbWrite(8'h00, 32'd1, 4'hF);
    wbWrite(8'h0C, 32'h00AB_CDEF, 4'hF);
    repeat (16) @(negedge clk);
    wbWrite(8'h00, 32'h0000_0004, 4'hF);
    checkOutput("abortBusy", 32'(busy_o), 32'd0);
    checkOutput("abortValid", 32'(stim_valid_o), 32'd0);
    wbRead(8'h14, rd);
    checkOutput("abortVecDone", rd, 32'd3);
    wbRead(8'h10, rd);
    checkOutput("abortSig", rd, 32'h0000_0009);
    wbRead(8'h04, rd);
    checkOutput("abortStatus", rd, 32'd0);
    wbRead(8'h0C, rd);
    checkOutput("seedKept", rd, 32'h0000_0010);
    checkOutput("abortNoIrq", 32'(irqCount - irqBefore), 32'd0);

    // Randomized runs.
    for (int t = 0; t < 8; t++) begin
      runVectors(1'($urandom), 24'($urandom), int'($urandom_range(1, 6)), 1'b1, 16'h0000);
    end

    // Reset in the middle of a run.
    wbWrite(8'h08, 32'd10, 4'hF);
    wbWrite(8'h00, 32'd1, 4'hF);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midStim", 32'(stim_o), 32'd0);
    checkOutput("midValid", 32'(stim_valid_o), 32'd0);
    checkOutput("midBusy", 32'(busy_o), 32'd0);
    checkOutput("midIrq", 32'(done_irq_o), 32'd0);
    checkOutput("midAck", 32'(wbs_ack_o), 32'd0);
    checkOutput("midDat", wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wbRead(8'h04, rd);
    checkOutput("midStatus", rd, 32'd0);
    wbRead(8'h14, rd);
    checkOutput("midVecDone", rd, 32'd0);
    wbRead(8'h08, rd);
    checkOutput("midNumVec", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
